// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of a pin waveform and
// recovers the duty code, flagging bad periods and a dead line.
module pwm_capture #(
  parameter  int PERIOD = 16,
  localparam int DUTY_W = $clog2(PERIOD),
  localparam int CNT_W  = $clog2(PERIOD) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              period_err,
  output logic              stuck_low
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_W-1:0] P   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_lrun;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_lrun_nxt;
  logic             w_timeout;

  always_comb begin
    w_rise = r_s2 & ~r_s3;
    w_fall = ~r_s2 & r_s3;
    if (r_s2) begin
      w_lrun_nxt = '0;
    end else if (r_lrun == P) begin
      w_lrun_nxt = r_lrun;
    end else begin
      w_lrun_nxt = r_lrun + ONE;
    end
    w_timeout = (w_lrun_nxt == P);
  end

  // Sync flops reset high so a pin already high never looks like a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_s3       <= 1'b1;
      r_state    <= WAIT_RISE;
      r_hcnt     <= '0;
      r_pcnt     <= '0;
      r_lrun     <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      r_s1       <= pwm_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_lrun     <= w_lrun_nxt;
      stuck_low  <= w_timeout;
      duty_valid <= 1'b0;
      unique case (r_state)
        WAIT_RISE: begin
          if (w_rise) begin
            r_state <= MEAS_HIGH;
            r_hcnt  <= ONE;
            r_pcnt  <= ONE;
          end
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            r_pcnt  <= r_pcnt + ONE;
            r_state <= MEAS_LOW;
          end else if (r_hcnt == P) begin
            // Line never fell within a period: report full duty.
            duty       <= DUTY_W'(PERIOD - 1);
            duty_valid <= 1'b1;
            period_err <= 1'b0;
            r_hcnt     <= ONE;
            r_pcnt     <= ONE;
          end else begin
            r_hcnt <= r_hcnt + ONE;
            r_pcnt <= r_pcnt + ONE;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            if (r_pcnt == P) begin
              duty       <= DUTY_W'(r_hcnt - ONE);
              duty_valid <= 1'b1;
              period_err <= 1'b0;
            end else begin
              period_err <= 1'b1;
            end
            r_hcnt  <= ONE;
            r_pcnt  <= ONE;
            r_state <= MEAS_HIGH;
          end else if (w_timeout) begin
            r_state <= WAIT_RISE;
          end else begin
            r_pcnt <= r_pcnt + ONE;
          end
        end
        default: r_state <= WAIT_RISE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expectations are derived from the
// driven high/low runs and matched against duty_valid and output levels.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic [3:0] duty;
  logic       duty_valid;
  logic       period_err;
  logic       stuck_low;

  pwm_capture #(.PERIOD(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .duty_valid(duty_valid),
    .period_err(period_err),
    .stuck_low (stuck_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {int cyc; int duty;} vexp_t;
  typedef struct {int cyc; int stuck; int err; int duty;} lexp_t;
  vexp_t vq[$];
  lexp_t lq[$];

  bit last_pin = 1'b1;
  bit open = 1'b0;
  int cur_h = 0;
  int cur_l = 0;
  int lowrun = 0;
  int exp_duty = 0;
  int exp_err = 0;

  // A pin value driven now shows up on the outputs three edges later.
  task automatic push_val(int d);
    vexp_t v;
    v.cyc = cyc + 3;
    v.duty = d;
    vq.push_back(v);
  endtask

  task automatic push_lvl(int stuck);
    lexp_t l;
    l.cyc = cyc + 3;
    l.stuck = stuck;
    l.err = exp_err;
    l.duty = exp_duty;
    lq.push_back(l);
  endtask

  task automatic drive(bit b);
    pwm_in = b;
    last_pin = b;
    @(negedge clk);
  endtask

  task automatic high_run(int n);
    for (int i = 0; i < n; i++) begin
      lowrun = 0;
      if (!last_pin) begin
        if (open) begin
          if (cur_h + cur_l == 16) begin
            exp_duty = cur_h - 1;
            exp_err = 0;
            push_val(exp_duty);
          end else begin
            exp_err = 1;
          end
        end
        push_lvl(0);
        open = 1'b1;
        cur_h = 1;
        cur_l = 0;
      end else if (open) begin
        if (cur_h == 16) begin
          exp_duty = 15;
          exp_err = 0;
          push_val(15);
          push_lvl(0);
          cur_h = 1;
        end else begin
          cur_h++;
        end
      end
      drive(1'b1);
    end
  endtask

  task automatic low_run(int n);
    for (int i = 0; i < n; i++) begin
      if (open) cur_l++;
      if (lowrun < 16) begin
        lowrun++;
        if (lowrun == 16) begin
          push_lvl(1);
          open = 1'b0;
        end
      end
      drive(1'b0);
    end
  endtask

  task automatic pwm_period(int h, int l);
    high_run(h);
    low_run(l);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_duty", duty, 0);
      chk("rst_valid", duty_valid, 0);
      chk("rst_err", period_err, 0);
      chk("rst_stuck", stuck_low, 0);
    end
    reset = 1'b0;
    last_pin = 1'b1;
    open = 1'b0;
    lowrun = 0;
    exp_duty = 0;
    exp_err = 0;
  endtask

  vexp_t mv;
  lexp_t ml;

  always @(negedge clk) begin
    if (duty_valid) begin
      if (vq.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        mv = vq.pop_front();
        chk("valid_cyc", cyc, mv.cyc);
        chk("valid_duty", duty, mv.duty);
      end
    end else if (vq.size() > 0 && vq[0].cyc <= cyc) begin
      mv = vq.pop_front();
      chk("missing_valid", 0, 1);
    end
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      ml = lq.pop_front();
      chk("lvl_stuck", stuck_low, ml.stuck);
      chk("lvl_err", period_err, ml.err);
      chk("lvl_duty", duty, ml.duty);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset(3);
    low_run(3);
    repeat (4) pwm_period(6, 10);
    repeat (4) pwm_period(1, 15);
    high_run(50);
    low_run(14);
    repeat (2) pwm_period(6, 14);
    repeat (3) pwm_period(10, 6);
    low_run(20);
    repeat (2) pwm_period(6, 10);
    high_run(8);
    do_reset(2);
    high_run(40);
    chk("hi_duty", duty, 0);
    chk("hi_valid", duty_valid, 0);
    chk("hi_err", period_err, 0);
    chk("hi_stuck", stuck_low, 0);
    low_run(4);
    repeat (3) pwm_period(4, 12);
    pwm_period(6, 10);
    high_run(6);
    low_run(5);
    do_reset(2);
    low_run(3);
    repeat (3) pwm_period(6, 10);
    low_run(20);
    repeat (5) @(negedge clk);
    chk("vq_empty", vq.size(), 0);
    chk("lq_empty", lq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the on-chip 4-bit PWM generator: samples an external PWM waveform on a pin, measures high time and period in `clk` cycles, and recovers the 4-bit duty code that produced it. It sits between a dedicated input pin and the ALU/LED output logic, so a second die or a loopback wire can feed a duty code back into the design. It also flags non-conforming periods and a dead (stuck-low) line.

## Interface

Parameters:
- `PERIOD`, default 16: expected PWM period in `clk` cycles. Must be a power of 2 and at least 4.
- Derived: `DUTY_W = log2(PERIOD)` (4). `CNT_W = log2(PERIOD)+1` (5).

Ports:
- `clk`  in  1: single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `pwm_in`  in  1: asynchronous PWM input from a pin.
- `duty`  out  DUTY_W: last successfully recovered duty code.
- `duty_valid`  out  1: one-cycle pulse when `duty` is (re)written by a good measurement.
- `period_err`  out  1: level. Set when the last completed period ≠ `PERIOD`; cleared by the next good measurement.
- `stuck_low`  out  1: level. Set after `PERIOD` consecutive low samples; cleared on the next rising edge.

## Operation

Synchronizer and edge detect:
- Three-flop chain s1→s2→s3. All three reset to 1, so a pin that is already high at reset never yields a false rise.
- rise = s2 & ~s3; fall = ~s2 & s3. All logic below uses s2 as "the sample".

Counters (all reset to 0):
- `hcnt` counts high samples.
- `pcnt` counts period samples.
- `lrun` counts consecutive s2==0 samples. It saturates at `PERIOD` and clears on any s2==1.

FSM states: WAIT_RISE (reset state), MEAS_HIGH, MEAS_LOW.
- **WAIT_RISE:**
  - On rise: go to MEAS_HIGH with hcnt=1, pcnt=1.
  - Constant high here produces no output.
- **MEAS_HIGH:**
  - s2 high, hcnt<PERIOD: hcnt++, pcnt++.
  - On fall: pcnt++, go to MEAS_LOW.
  - hcnt==PERIOD and s2 still high (full-duty case): duty=PERIOD-1, duty_valid pulse, period_err=0, hcnt=1, pcnt=1, stay in MEAS_HIGH.
- **MEAS_LOW:**
  - s2 low: pcnt++.
  - On rise, the measurement completes:
    - If pcnt==PERIOD: duty=hcnt-1, duty_valid pulse, period_err=0.
    - Otherwise: period_err=1, duty held, no duty_valid.
  - In both cases the same cycle restarts MEAS_HIGH with hcnt=1, pcnt=1. The rise both closes one period and opens the next.
  - When lrun reaches PERIOD: go to WAIT_RISE.
- **stuck_low:**
  - Set when lrun==PERIOD, in any state.
  - Cleared on rise.
  - Does not alter `duty` or `period_err`.

Arithmetic:
- Generator duty d gives d+1 high samples and 15-d low samples, so hcnt=d+1, pcnt=16, and duty=d.
- hcnt-1 never underflows, because hcnt≥1 in MEAS_HIGH/MEAS_LOW.
- pcnt cannot exceed 2·PERIOD-1 before the lrun timeout or the full-duty wrap fires, so CNT_W is sufficient.

## Timing

- Reset values: duty=0, duty_valid=0, period_err=0, stuck_low=0, state=WAIT_RISE, counters 0, s1/s2/s3=1.
- A reset asserted mid-measurement takes effect at the next edge. The partial measurement is discarded, and no duty_valid is produced until one full rise-to-rise period after the first post-reset rise.
- All outputs are registered.
- Pin-to-output latency: if edge n first samples pwm_in high on a closing rise, the rise is detected after edge n+1 and outputs update at edge n+2.
- duty_valid is exactly one cycle wide. In steady state at a conforming period it recurs every `PERIOD` cycles.
- stuck_low asserts at the edge on which the `PERIOD`-th consecutive low sample of s2 is taken.
- Simultaneous events:
  - A rise clears lrun in the same cycle, so stuck_low and a rise never coexist.
  - A measurement close and a new-period open always occur on the same edge.

## Test plan

- Conforming PWM, period 16, duty 5 (6 high / 10 low), repeated 4 periods → first duty_valid at the second rise. Then duty=5, period_err=0, pulses exactly 16 cycles apart.
- Duty 0 (1 high / 15 low) → duty=0 every 16 cycles. Then switch to constant high → duty=15, one pulse every 16 cycles, stuck_low=0.
- Period 20 (6 high / 14 low) ×2 → period_err=1, no duty_valid, duty holds the prior value. Return to period 16, duty 9 → period_err=0, duty=9.
- Line held low for 20 cycles after a valid stream → stuck_low=1 at the 16th low sample, state WAIT_RISE. Then a rise → stuck_low=0, and a conforming period produces duty_valid after one full period.
- Reset with pwm_in held high for 40 cycles → no duty_valid, all outputs 0. Then a low→high start followed by duty 3 → first duty_valid=3 at the second rise.
- Reset asserted mid-MEAS_LOW → all outputs 0 at the next edge, no spurious duty_valid. The first pulse arrives one full period after the next rise.
